// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// The CSUM state exists only when IMEM_LOADER_CSUM_EN is defined.
package imem_loader_pkg;

    localparam int unsigned ADDR_W         = 8;
    localparam int unsigned DEF_MAX_WORDS  = 64;
    localparam int unsigned BYTES_PER_WORD = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
`ifdef IMEM_LOADER_CSUM_EN
    localparam logic [2:0] S_CSUM = 3'd3;
`endif
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_LEN  = S_LEN,
        ST_DATA = S_DATA,
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM = S_CSUM,
`endif
        ST_DONE = S_DONE,
        ST_ERR  = S_ERR
    } state_e;

    // The processor may only run once a load has finished cleanly or none is in progress.
    function automatic logic state_holds_cpu(input logic [2:0] s);
        return !((s == S_IDLE) || (s == S_DONE));
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; flags the word on its 4th byte.
// Independent of IMEM_LOADER_CSUM_EN.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [23:0] r_shift;
    logic [1:0]  r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_idx   <= r_idx + 2'd1;
        end
    end

    // The 4th byte is not stored; it is combined with the three held bytes directly.
    assign o_word_valid = i_load && (r_idx == 2'(BYTES_PER_WORD - 1));
    assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader with processor hold.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err
);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [7:0]        r_n;
    logic [ADDR_W-1:0] r_widx;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_hold;

    logic              w_rx_ready;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_data_load;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_last_word;
    logic              w_len_bad;

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        r_csum;
`endif

    always_comb begin
        w_rx_ready = 1'b0;
        case (r_state)
            S_LEN, S_DATA: w_rx_ready = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM:        w_rx_ready = 1'b1;
`endif
            default:       w_rx_ready = 1'b0;
        endcase
    end

    assign w_accept    = i_rx_valid && w_rx_ready;
    assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_data_load = w_accept && (r_state == S_DATA);
    assign w_len_bad   = (i_rx_data == 8'd0) || (32'(i_rx_data) > MAX_WORDS);
    assign w_last_word = w_word_valid && (r_widx == (r_n - 8'd1));

    byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_start_ok),
        .i_load       (w_data_load),
        .i_byte       (i_rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) w_next_state = S_LEN;
            end
            S_LEN: begin
                if (w_accept) w_next_state = w_len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
                if (w_last_word) w_next_state = S_CSUM;
`else
                if (w_last_word) w_next_state = S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (w_accept) w_next_state = (i_rx_data == r_csum) ? S_DONE : S_ERR;
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_widx  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_we    <= w_word_valid;
            // Hold stays up through the final write cycle even when entering DONE.
            r_hold  <= state_holds_cpu(w_next_state) || w_word_valid;
            if (w_start_ok) begin
                r_widx <= '0;
            end else if (w_word_valid) begin
                r_widx <= r_widx + 1'b1;
            end
            if (w_word_valid) begin
                r_addr  <= {r_widx[ADDR_W-3:0], 2'b00};
                r_wdata <= w_word;
            end
            if (w_accept && (r_state == S_LEN) && !w_len_bad) begin
                r_n <= i_rx_data;
            end
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_csum <= '0;
        end else if (w_accept && ((r_state == S_LEN) || (r_state == S_DATA))) begin
            r_csum <= r_csum ^ i_rx_data;
        end
    end
`endif

    assign o_rx_ready   = w_rx_ready;
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_cpu_hold   = r_hold;
    assign o_done       = (r_state == S_DONE);
    assign o_err        = (r_state == S_ERR);

endmodule
